// File: rtl/ecc_pkg.sv
// ecc_pkg: shared state encoding for the ECC scalar-multiplication controller
package ecc_pkg;
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SCAN     = 3'd1;
    localparam logic [2:0] ST_DBL_WAIT = 3'd2;
    localparam logic [2:0] ST_ADD_WAIT = 3'd3;
    localparam logic [2:0] ST_FIN      = 3'd4;
endpackage

// File: rtl/ecc_scalar_mul_ctrl_if.sv
// ecc_scalar_mul_ctrl_if: host request/result and point-unit operand/result bundle
interface ecc_scalar_mul_ctrl_if #(parameter int integer_size = 64);
    logic                    go;
    logic [integer_size-1:0] k, Px, Py;
    logic                    infiniteP;
    logic [integer_size-1:0] Rx, Ry;
    logic                    infiniteR, done, busy;
    logic [integer_size-1:0] op_Px, op_Py, op_Qx, op_Qy;
    logic                    op_infP, op_infQ, add_go, dbl_go, unit_done;
    logic [integer_size-1:0] res_x, res_y;
    logic                    res_inf;
    modport master (
        output go, k, Px, Py, infiniteP, unit_done, res_x, res_y, res_inf,
        input  Rx, Ry, infiniteR, done, busy, op_Px, op_Py, op_infP, op_Qx, op_Qy, op_infQ, add_go, dbl_go
    );
    modport slave (
        input  go, k, Px, Py, infiniteP, unit_done, res_x, res_y, res_inf,
        output Rx, Ry, infiniteR, done, busy, op_Px, op_Py, op_infP, op_Qx, op_Qy, op_infQ, add_go, dbl_go
    );
endinterface

// File: rtl/ecc_scalar_mul_ctrl.sv
// ecc_scalar_mul_ctrl: left-to-right double-and-add sequencer driving external point units
module ecc_scalar_mul_ctrl
    import ecc_pkg::*;
#(
    parameter int integer_size = 64
) (
    input logic                  clk,
    input logic                  rst,
    ecc_scalar_mul_ctrl_if.slave bus
);
    localparam int IW = (integer_size > 1) ? $clog2(integer_size) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(integer_size - 1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);
    localparam logic [integer_size-1:0] ZERO = '0;
    typedef struct packed {
        logic [integer_size-1:0] x;
        logic [integer_size-1:0] y;
        logic                    inf;
    } point_t;
    localparam point_t INF_PT = '{ZERO, ZERO, 1'b1};

    logic [2:0]              r_state;
    logic [IW-1:0]           r_idx;
    logic [integer_size-1:0] r_k;
    point_t                  r_p, r_r, r_op_p, r_op_q, r_out;
    logic                    r_add_go, r_dbl_go;
    point_t                  w_res, w_c, w_fin;
    logic                    w_bit, w_eqx, w_eqy, w_add, w_dbl_add, w_last;

    // Add-step decision on the candidate R: the unit result in DBL_WAIT, else the held R
    always_comb begin
        w_res     = '{bus.res_x, bus.res_y, bus.res_inf};
        w_c       = (r_state == ST_DBL_WAIT) ? w_res : r_r;
        w_bit     = r_k[r_idx];
        w_eqx     = w_c.x == r_p.x;
        w_eqy     = w_c.y == r_p.y;
        w_add     = w_bit && !w_c.inf && !w_eqx;
        w_dbl_add = w_bit && !w_c.inf && w_eqx && w_eqy;
        w_last    = r_idx == '0;
        w_fin     = r_r.inf ? INF_PT : r_r;
    end

    assign bus.Rx        = (r_state == ST_FIN) ? w_fin.x : r_out.x;
    assign bus.Ry        = (r_state == ST_FIN) ? w_fin.y : r_out.y;
    assign bus.infiniteR = (r_state == ST_FIN) ? w_fin.inf : r_out.inf;
    assign bus.done      = r_state == ST_FIN;
    assign bus.busy      = r_state != ST_IDLE;
    assign bus.add_go    = r_add_go;
    assign bus.dbl_go    = r_dbl_go;
    assign bus.op_Px     = r_op_p.x;
    assign bus.op_Py     = r_op_p.y;
    assign bus.op_infP   = r_op_p.inf;
    assign bus.op_Qx     = r_op_q.x;
    assign bus.op_Qy     = r_op_q.y;
    assign bus.op_infQ   = r_op_q.inf;

    // Scan sequencer: one bit per pass, doubling then conditional add, operands held until unit_done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_k      <= '0;
            r_p      <= '0;
            r_r      <= '0;
            r_op_p   <= '0;
            r_op_q   <= '0;
            r_out    <= '0;
            r_add_go <= 1'b0;
            r_dbl_go <= 1'b0;
        end else begin
            r_add_go <= 1'b0;
            r_dbl_go <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.go) begin
                    r_k     <= bus.k;
                    r_p     <= '{bus.Px, bus.Py, bus.infiniteP};
                    r_r     <= INF_PT;
                    r_idx   <= IDX_TOP;
                    r_state <= (bus.k == ZERO || bus.infiniteP) ? ST_FIN : ST_SCAN;
                end
                ST_SCAN, ST_DBL_WAIT: begin
                    if (r_state == ST_SCAN && !r_r.inf) begin
                        r_dbl_go <= 1'b1;
                        r_op_p   <= r_r;
                        r_state  <= ST_DBL_WAIT;
                    end else if (r_state == ST_SCAN || bus.unit_done) begin
                        if (w_add || w_dbl_add) begin
                            r_add_go <= w_add;
                            r_dbl_go <= w_dbl_add;
                            r_op_p   <= w_c;
                            r_op_q   <= '{r_p.x, r_p.y, 1'b0};
                            r_r      <= w_c;
                            r_state  <= ST_ADD_WAIT;
                        end else begin
                            r_r     <= !w_bit ? w_c : w_c.inf ? r_p : INF_PT;
                            r_idx   <= w_last ? r_idx : r_idx - IDX_ONE;
                            r_state <= w_last ? ST_FIN : ST_SCAN;
                        end
                    end
                end
                ST_ADD_WAIT: if (bus.unit_done) begin
                    r_r     <= w_res;
                    r_idx   <= w_last ? r_idx : r_idx - IDX_ONE;
                    r_state <= w_last ? ST_FIN : ST_SCAN;
                end
                ST_FIN: begin
                    r_out   <= w_fin;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule
